// File: rtl/tof_shot_avg_pkg.sv
// Definitions shared by the TDC top and its downstream TOF shot averager.
// Timeout/saturation limits live here so both blocks agree on what a valid code is.
package tof_shot_avg_pkg;

  localparam int unsigned TDC_TOF_W     = 13;
  localparam int unsigned TDC_MIN_VALID = 1;
  localparam int unsigned TDC_MAX_VALID = 8000;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    CALC  = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/tof_shot_avg_if.sv
// Shot input / averaged result bundle between the TDC, the averager and range processing.
interface tof_shot_avg_if
  import tof_shot_avg_pkg::*;
#(
  parameter int unsigned TOF_W      = TDC_TOF_W,
  parameter int unsigned SHOTS_LOG2 = 3,
  parameter int unsigned REJ_LIMIT  = 4
);
  localparam int unsigned REJ_W = $clog2(REJ_LIMIT + 1);

  logic [TOF_W-1:0]    tof_in;
  logic                tof_valid;
  logic [TOF_W-1:0]    avg_out;
  logic                avg_err;
  logic                avg_valid;
  logic                avg_ready;
  logic [SHOTS_LOG2:0] hit_cnt;
  logic [REJ_W-1:0]    rej_cnt;
  logic                drop_sticky;

  modport master (
    output tof_in, tof_valid, avg_ready,
    input  avg_out, avg_err, avg_valid, hit_cnt, rej_cnt, drop_sticky
  );

  modport slave (
    input  tof_in, tof_valid, avg_ready,
    output avg_out, avg_err, avg_valid, hit_cnt, rej_cnt, drop_sticky
  );

endinterface

// File: rtl/tof_range_gate.sv
// Purely combinational accept/reject classification of a TDC shot against the valid window.
module tof_range_gate
  import tof_shot_avg_pkg::*;
#(
  parameter int unsigned TOF_W     = TDC_TOF_W,
  parameter int unsigned MIN_VALID = TDC_MIN_VALID,
  parameter int unsigned MAX_VALID = TDC_MAX_VALID
) (
  input  logic [TOF_W-1:0] tof_in,
  input  logic             tof_valid,
  output logic             accept,
  output logic             reject
);

  localparam logic [TOF_W-1:0] LO = TOF_W'(MIN_VALID);
  localparam logic [TOF_W-1:0] HI = TOF_W'(MAX_VALID);

  logic in_range;

  assign in_range = (tof_in >= LO) && (tof_in <= HI);
  assign accept   = tof_valid && in_range;
  assign reject   = tof_valid && !in_range;

endmodule

// File: rtl/tof_shot_avg.sv
// Accumulates 2^SHOTS_LOG2 in-range TDC shots and emits one rounded mean per frame,
// aborting the frame with avg_err when REJ_LIMIT shots are rejected.
module tof_shot_avg
  import tof_shot_avg_pkg::*;
#(
  parameter int unsigned TOF_W      = TDC_TOF_W,
  parameter int unsigned SHOTS_LOG2 = 3,
  parameter int unsigned MIN_VALID  = TDC_MIN_VALID,
  parameter int unsigned MAX_VALID  = TDC_MAX_VALID,
  parameter int unsigned REJ_LIMIT  = 4
) (
  input logic           clk,
  input logic           rst,
  input logic           clr,
  tof_shot_avg_if.slave bus
);

  localparam int unsigned SUM_W = TOF_W + SHOTS_LOG2;
  localparam int unsigned HIT_W = SHOTS_LOG2 + 1;
  localparam int unsigned REJ_W = $clog2(REJ_LIMIT + 1);

  localparam logic [HIT_W-1:0] FRAME_LAST = HIT_W'((1 << SHOTS_LOG2) - 1);
  localparam logic [REJ_W-1:0] REJ_LAST   = REJ_W'(REJ_LIMIT - 1);
  localparam logic [SUM_W:0]   HALF       = (SUM_W + 1)'((1 << SHOTS_LOG2) >> 1);

  state_t state, state_nx;

  logic             accept, reject;
  logic             take_hit, take_rej, do_calc, do_release, do_drop;
  logic [SUM_W-1:0] sum;
  logic [SUM_W:0]   rounded;
  logic [HIT_W-1:0] hit_cnt;
  logic [REJ_W-1:0] rej_cnt;
  logic             err_pend;
  logic [TOF_W-1:0] avg_out;
  logic             avg_err, avg_valid, drop_sticky;

  tof_range_gate #(
    .TOF_W     (TOF_W),
    .MIN_VALID (MIN_VALID),
    .MAX_VALID (MAX_VALID)
  ) u_gate (
    .tof_in    (bus.tof_in),
    .tof_valid (bus.tof_valid),
    .accept    (accept),
    .reject    (reject)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= ACCUM;
    else if (clr) state <= ACCUM;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ACCUM: if ((accept && hit_cnt == FRAME_LAST) || (reject && rej_cnt == REJ_LAST))
               state_nx = CALC;
      CALC:  state_nx = HOLD;
      HOLD:  if (avg_valid && bus.avg_ready) state_nx = ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  always_comb begin
    take_hit   = 1'b0;
    take_rej   = 1'b0;
    do_calc    = 1'b0;
    do_release = 1'b0;
    do_drop    = 1'b0;
    unique case (state)
      ACCUM: begin
        take_hit = accept;
        take_rej = reject;
      end
      CALC: begin
        do_calc = 1'b1;
        do_drop = bus.tof_valid;
      end
      HOLD: begin
        do_release = avg_valid && bus.avg_ready;
        do_drop    = bus.tof_valid;
      end
      default: ;
    endcase
  end

  // One extra bit on the rounding add keeps the carry out of a full-scale sum.
  assign rounded = {1'b0, sum} + HALF;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum         <= '0;
      hit_cnt     <= '0;
      rej_cnt     <= '0;
      err_pend    <= 1'b0;
      avg_out     <= '0;
      avg_err     <= 1'b0;
      avg_valid   <= 1'b0;
      drop_sticky <= 1'b0;
    end else if (clr) begin
      sum         <= '0;
      hit_cnt     <= '0;
      rej_cnt     <= '0;
      err_pend    <= 1'b0;
      avg_valid   <= 1'b0;
      drop_sticky <= 1'b0;
    end else begin
      if (take_hit) begin
        sum     <= sum + SUM_W'(bus.tof_in);
        hit_cnt <= hit_cnt + HIT_W'(1);
      end
      if (take_rej) begin
        rej_cnt <= rej_cnt + REJ_W'(1);
        if (rej_cnt == REJ_LAST) err_pend <= 1'b1;
      end
      if (do_calc) begin
        avg_out   <= err_pend ? '0 : TOF_W'(rounded >> SHOTS_LOG2);
        avg_err   <= err_pend;
        avg_valid <= 1'b1;
      end
      if (do_release) begin
        avg_valid <= 1'b0;
        sum       <= '0;
        hit_cnt   <= '0;
        rej_cnt   <= '0;
        err_pend  <= 1'b0;
      end
      if (do_drop) drop_sticky <= 1'b1;
    end
  end

  assign bus.avg_out     = avg_out;
  assign bus.avg_err     = avg_err;
  assign bus.avg_valid   = avg_valid;
  assign bus.hit_cnt     = hit_cnt;
  assign bus.rej_cnt     = rej_cnt;
  assign bus.drop_sticky = drop_sticky;

endmodule

// File: tb/tb_tof_shot_avg.sv
// Directed bench for tof_shot_avg: table of whole frames plus hold/clr/rst sequences.
module tb_tof_shot_avg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  tof_shot_avg_if #(.TOF_W(13), .SHOTS_LOG2(3), .REJ_LIMIT(4)) bus ();

  tof_shot_avg #(
    .TOF_W      (13),
    .SHOTS_LOG2 (3),
    .MIN_VALID  (1),
    .MAX_VALID  (8000),
    .REJ_LIMIT  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0]         n;
    logic [0:11][12:0]  s;
    logic [12:0]        avg;
    logic               err;
    logic [3:0]         hit;
    logic [2:0]         rej;
  } vec_t;

  vec_t vt [8];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [0:11][12:0] pk(input int a0, a1, a2, a3, a4, a5,
                                           a6, a7, a8, a9, a10, a11);
    return {13'(a0), 13'(a1), 13'(a2), 13'(a3), 13'(a4), 13'(a5),
            13'(a6), 13'(a7), 13'(a8), 13'(a9), 13'(a10), 13'(a11)};
  endfunction

  task automatic send(input int v, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.tof_valid = 1'b1;
      bus.tof_in    = 13'(v);
    end
    @(negedge clk);
    bus.tof_valid = 1'b0;
  endtask

  // Called right after send() with avg_ready high: CALC, then one cycle of avg_valid.
  task automatic expect_frame(input string nm, input int exp);
    chk({nm, " calc_valid"}, 32'(bus.avg_valid), 0);
    @(negedge clk);
    chk({nm, " valid"}, 32'(bus.avg_valid), 1);
    chk({nm, " avg"},   32'(bus.avg_out), 32'(exp));
    chk({nm, " err"},   32'(bus.avg_err), 0);
    @(negedge clk);
    chk({nm, " released"}, 32'(bus.avg_valid), 0);
  endtask

  initial begin
    bus.tof_valid = 1'b0;
    bus.tof_in    = '0;
    bus.avg_ready = 1'b1;

    vt[0] = '{4'd8,  pk(100,100,100,100,100,100,100,100,0,0,0,0),          13'd100,  1'b0, 4'd8, 3'd0};
    vt[1] = '{4'd8,  pk(100,101,102,103,104,105,106,107,0,0,0,0),          13'd104,  1'b0, 4'd8, 3'd0};
    vt[2] = '{4'd8,  pk(100,100,100,100,101,101,101,101,0,0,0,0),          13'd101,  1'b0, 4'd8, 3'd0};
    vt[3] = '{4'd5,  pk(0,8191,50,8001,8100,0,0,0,0,0,0,0),                13'd0,    1'b1, 4'd1, 3'd4};
    vt[4] = '{4'd8,  pk(8000,8000,8000,8000,8000,8000,8000,8000,0,0,0,0),  13'd8000, 1'b0, 4'd8, 3'd0};
    vt[5] = '{4'd10, pk(1,8000,0,1,8000,8001,1,8000,1,8000,0,0),           13'd4001, 1'b0, 4'd8, 3'd2};
    vt[6] = '{4'd11, pk(8191,8191,8191,7,7,7,7,7,7,7,7,0),                 13'd7,    1'b0, 4'd8, 3'd3};
    vt[7] = '{4'd8,  pk(1,2,3,4,5,6,7,7,0,0,0,0),                          13'd4,    1'b0, 4'd8, 3'd0};

    repeat (2) @(negedge clk);
    chk("rst avg_out",     32'(bus.avg_out), 0);
    chk("rst avg_err",     32'(bus.avg_err), 0);
    chk("rst avg_valid",   32'(bus.avg_valid), 0);
    chk("rst hit_cnt",     32'(bus.hit_cnt), 0);
    chk("rst rej_cnt",     32'(bus.rej_cnt), 0);
    chk("rst drop_sticky", 32'(bus.drop_sticky), 0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < int'(vt[i].n); k++) begin
        @(negedge clk);
        bus.tof_valid = 1'b1;
        bus.tof_in    = vt[i].s[k];
      end
      @(negedge clk);
      bus.tof_valid = 1'b0;
      chk($sformatf("v%0d calc_valid", i), 32'(bus.avg_valid), 0);
      chk($sformatf("v%0d hit", i),        32'(bus.hit_cnt), 32'(vt[i].hit));
      chk($sformatf("v%0d rej", i),        32'(bus.rej_cnt), 32'(vt[i].rej));
      @(negedge clk);
      chk($sformatf("v%0d valid", i),      32'(bus.avg_valid), 1);
      chk($sformatf("v%0d avg", i),        32'(bus.avg_out), 32'(vt[i].avg));
      chk($sformatf("v%0d err", i),        32'(bus.avg_err), 32'(vt[i].err));
      chk($sformatf("v%0d hold_hit", i),   32'(bus.hit_cnt), 32'(vt[i].hit));
      @(negedge clk);
      chk($sformatf("v%0d released", i),   32'(bus.avg_valid), 0);
      chk($sformatf("v%0d hit_clr", i),    32'(bus.hit_cnt), 0);
      chk($sformatf("v%0d rej_clr", i),    32'(bus.rej_cnt), 0);
      chk($sformatf("v%0d avg_kept", i),   32'(bus.avg_out), 32'(vt[i].avg));
    end

    // Back-pressure: result must stay put and a HOLD-time strobe must be dropped.
    bus.avg_ready = 1'b0;
    send(300, 8);
    @(negedge clk);
    chk("hold first valid", 32'(bus.avg_valid), 1);
    chk("hold first avg",   32'(bus.avg_out), 300);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("hold c%0d valid", c), 32'(bus.avg_valid), 1);
      chk($sformatf("hold c%0d avg", c),   32'(bus.avg_out), 300);
      bus.tof_valid = (c == 3);
      bus.tof_in    = 13'd500;
    end
    chk("hold drop_sticky", 32'(bus.drop_sticky), 1);
    chk("hold hit_cnt",     32'(bus.hit_cnt), 8);
    bus.avg_ready = 1'b1;
    @(negedge clk);
    chk("hold released",     32'(bus.avg_valid), 0);
    chk("hold next hit",     32'(bus.hit_cnt), 0);
    chk("hold drop kept",    32'(bus.drop_sticky), 1);
    chk("hold avg kept",     32'(bus.avg_out), 300);

    // Partial frame killed by clr, with a concurrent strobe that must be ignored.
    send(50, 4);
    chk("clr pre hit", 32'(bus.hit_cnt), 4);
    clr = 1'b1;
    bus.tof_valid = 1'b1;
    bus.tof_in    = 13'd77;
    @(negedge clk);
    clr = 1'b0;
    bus.tof_valid = 1'b0;
    chk("clr hit",   32'(bus.hit_cnt), 0);
    chk("clr drop",  32'(bus.drop_sticky), 0);
    repeat (3) @(negedge clk);
    chk("clr no output", 32'(bus.avg_valid), 0);
    send(200, 8);
    expect_frame("clr frame", 200);

    // Asynchronous reset mid-frame wipes everything, including the last result.
    send(60, 4);
    chk("rst pre hit", 32'(bus.hit_cnt), 4);
    #2 rst = 1'b0;
    #1;
    chk("arst avg_out",   32'(bus.avg_out), 0);
    chk("arst hit_cnt",   32'(bus.hit_cnt), 0);
    chk("arst avg_valid", 32'(bus.avg_valid), 0);
    chk("arst avg_err",   32'(bus.avg_err), 0);
    @(negedge clk);
    rst = 1'b1;
    send(123, 8);
    expect_frame("post rst frame", 123);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
